// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives a 3-input CUT through rows 000..111 and
// captures the single output into an 8-bit truth-table code. The output
// for row r lands in code bit (7-r), so row 000 is the MSB.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] expected_i,
  input  logic       cut_out_i,
  output logic       in1_o,
  output logic       in2_o,
  output logic       in3_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] table_o,
  output logic       match_o,
  output logic       unstable_o
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMP1,
    SAMP2,
    DONE
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] scratch_q, scratch_d;
  logic       s1_q, s1_d;
  logic       sticky_q, sticky_d;
  logic       done_q, done_d;
  logic [7:0] table_q, table_d;
  logic       match_q, match_d;
  logic       unstable_q, unstable_d;
  logic       sync1_q, sync2_q;

  // Two-flop synchroniser for the asynchronous CUT output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cut_out_i;
      sync2_q <= sync1_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      scratch_q  <= '0;
      s1_q       <= 1'b0;
      sticky_q   <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= '0;
      match_q    <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      scratch_q  <= scratch_d;
      s1_q       <= s1_d;
      sticky_q   <= sticky_d;
      done_q     <= done_d;
      table_q    <= table_d;
      match_q    <= match_d;
      unstable_q <= unstable_d;
    end
  end

  // Sweep sequencing: settle, double-sample, advance row, publish result.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    scratch_d  = scratch_q;
    s1_d       = s1_q;
    sticky_d   = sticky_q;
    done_d     = 1'b0;
    table_d    = table_q;
    match_d    = match_q;
    unstable_d = unstable_q;

    unique case (state_q)
      IDLE: begin
        row_d = '0;
        if (start_i) begin
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = '0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (abort_i) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) state_d = SAMP1;
        end
      end
      SAMP1: begin
        if (abort_i) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          s1_d    = sync2_q;
          state_d = SAMP2;
        end
      end
      SAMP2: begin
        if (abort_i) begin
          row_d   = '0;
          state_d = IDLE;
        end else begin
          // ~row equals 7-row for a 3-bit row index.
          scratch_d[~row_q] = sync2_q;
          if (sync2_q != s1_q) sticky_d = 1'b1;
          if (row_q == 3'd7) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + 3'd1;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        table_d    = scratch_q;
        match_d    = (scratch_q == expected_i);
        unstable_d = sticky_q;
        done_d     = 1'b1;
        row_d      = '0;
        state_d    = IDLE;
      end
      default: begin
        row_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign in1_o      = row_q[2];
  assign in2_o      = row_q[1];
  assign in3_o      = row_q[0];
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign table_o    = table_q;
  assign match_o    = match_q;
  assign unstable_o = unstable_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 1) each
// driving a selectable gate-level CUT model; results go through a scoreboard.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0;
  logic [7:0] expected = 8'h8E;
  logic [1:0] sel = 2'd0;
  logic       glitch = 1'b0;

  logic       in1_a, in2_a, in3_a, busy_a, done_a, match_a, unst_a, cut_a;
  logic [7:0] tbl_a;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, match_b, unst_b, cut_b;
  logic [7:0] tbl_b;

  typedef struct {
    logic [7:0] code;
    logic       match;
    logic       unst;
    logic       chk_unst;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_pass = 0;

  // CUT models: 0x8E gate network, buffer of in1, buffer of in3, constant 0.
  function automatic logic cut_fn(input logic [1:0] s, input logic a, input logic b, input logic c);
    case (s)
      2'd0:    return (a & ~(b & c)) | (~a & ~b & ~c);
      2'd1:    return a;
      2'd2:    return c;
      default: return 1'b0;
    endcase
  endfunction

  assign cut_a = cut_fn(sel, in1_a, in2_a, in3_a) ^ glitch;
  assign cut_b = cut_fn(sel, in1_b, in2_b, in3_b);

  truth_table_sweeper #(.SETTLE_CYCLES(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_a),
    .expected_i(expected), .cut_out_i(cut_a),
    .in1_o(in1_a), .in2_o(in2_a), .in3_o(in3_a), .busy_o(busy_a),
    .done_o(done_a), .table_o(tbl_a), .match_o(match_a), .unstable_o(unst_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(1'b0),
    .expected_i(expected), .cut_out_i(cut_b),
    .in1_o(in1_b), .in2_o(in2_b), .in3_o(in3_b), .busy_o(busy_b),
    .done_o(done_b), .table_o(tbl_b), .match_o(match_b), .unstable_o(unst_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One sweep: push expectation, pulse start, track drives, pop on done.
  task automatic sweep(input bit use_b, input logic [7:0] exp_code, input bit exp_unst,
                       input bit chk_unst, input int glitch_row, input int restart_k);
    int   s, k, drv_err;
    bit   seen;
    logic [2:0] drv;
    exp_t e;
    s = use_b ? 1 : 4;
    e.code = exp_code;
    e.match = (exp_code == expected);
    e.unst = exp_unst;
    e.chk_unst = chk_unst;
    e.lat = 8 * (s + 2) + 1;
    sb.push_back(e);
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_after_start", use_b ? busy_b : busy_a, 1);
    k = 0;
    drv_err = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      drv = use_b ? {in1_b, in2_b, in3_b} : {in1_a, in2_a, in3_a};
      if (k < 8 * (s + 2) && drv != 3'(k / (s + 2))) drv_err++;
      glitch = (glitch_row >= 0) && (k >= glitch_row * (s + 2) + s - 1) &&
               (k <= glitch_row * (s + 2) + s + 1);
      if (use_b) start_b = (k == restart_k); else start_a = (k == restart_k);
      @(negedge clk);
      k++;
      if (use_b ? done_b : done_a) seen = 1'b1;
    end
    glitch = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    e = sb.pop_front();
    chk("latency", k, e.lat);
    chk("table", use_b ? tbl_b : tbl_a, e.code);
    chk("match", use_b ? match_b : match_a, e.match);
    if (e.chk_unst) chk("unstable", use_b ? unst_b : unst_a, e.unst);
    chk("drive_seq_errors", drv_err, 0);
    @(negedge clk);
    chk("done_one_cycle", use_b ? done_b : done_a, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dn;
    #1 rst = 1'b1;
    #3;
    chk("reset_a", {in1_a, in2_a, in3_a, busy_a, done_a, tbl_a, match_a, unst_a}, 0);
    chk("reset_b", {in1_b, in2_b, in3_b, busy_b, done_b, tbl_b, match_b, unst_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    expected = 8'h8E;
    sel = 2'd0; sweep(1'b0, 8'h8E, 1'b0, 1'b1, -1, -1);
    sel = 2'd1; sweep(1'b0, 8'h0F, 1'b0, 1'b1, -1, -1);
    sel = 2'd2; sweep(1'b0, 8'h55, 1'b0, 1'b1, -1, -1);
    sel = 2'd3; sweep(1'b0, 8'h00, 1'b0, 1'b1, -1, -1);
    sel = 2'd0; sweep(1'b0, 8'h9E, 1'b1, 1'b1, 3, -1);
    sel = 2'd0; sweep(1'b0, 8'h8E, 1'b0, 1'b1, -1, -1);
    sel = 2'd0; sweep(1'b0, 8'h8E, 1'b0, 1'b1, -1, 10);

    // start together with abort in IDLE, then abort during row 5
    @(negedge clk);
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    chk("start_beats_abort", busy_a, 1);
    repeat (31) @(negedge clk);
    chk("row5_before_abort", {in1_a, in2_a, in3_a}, 3'd5);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_to_idle", {busy_a, in1_a, in2_a, in3_a}, 0);
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_results_held", {tbl_a, match_a, unst_a}, {8'h8E, 1'b1, 1'b0});

    sel = 2'd0; sweep(1'b1, 8'h8E, 1'b0, 1'b0, -1, -1);
    sel = 2'd1; sweep(1'b1, 8'h0F, 1'b0, 1'b0, -1, -1);

    // asynchronous reset during row 2
    sel = 2'd0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (13) @(negedge clk);
    chk("row2_before_rst", {in1_a, in2_a, in3_a}, 3'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_a", {in1_a, in2_a, in3_a, busy_a, done_a, tbl_a, match_a, unst_a}, 0);
    chk("rst_async_b", {tbl_b, match_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b0, 8'h8E, 1'b0, 1'b1, -1, -1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
